ofdm_symbol_sequencer: RTL and testbench



---
 rtl/ofdm_pkg.sv | 34 +++
 rtl/ofdm_symbol_sequencer_if.sv | 42 ++++
 rtl/ofdm_symbol_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ofdm_symbol_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ofdm_pkg
// Brief   : Shared defaults, derived widths and state encoding for the
//           OFDM symbol sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package ofdm_pkg;

    localparam int WIDTH    = 16;
    localparam int FFT_SIZE = 16;
    localparam int CP_LEN   = 4;
    localparam int NUM_SYM  = 6;

    // Counter width that never collapses to zero bits for tiny parameters.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int SYM_W  = clog2_min1(NUM_SYM);
    localparam int SAMP_W = clog2_min1(max2(FFT_SIZE, CP_LEN));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        DATA = 2'd2
    } state_e;

endpackage : ofdm_pkg
`default_nettype wire

// File: rtl/ofdm_symbol_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ofdm_symbol_sequencer_if
// Brief   : Sample-in / FFT-out signal bundle of the OFDM symbol sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface ofdm_symbol_sequencer_if
    import ofdm_pkg::*;
#(
    parameter int DATA_W = ofdm_pkg::WIDTH,
    parameter int IDX_W  = ofdm_pkg::SYM_W
) ();

    logic              en;
    logic [DATA_W-1:0] din_real;
    logic [DATA_W-1:0] din_imag;
    logic              abort;
    logic              fft_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_sop;
    logic              out_eop;
    logic [IDX_W-1:0]  sym_idx;
    logic              frame_done;
    logic              drop_err;

    modport master (
        output en, din_real, din_imag, abort, fft_ready,
        input  out_valid, out_real, out_imag, out_sop, out_eop,
               sym_idx, frame_done, drop_err
    );

    modport slave (
        input  en, din_real, din_imag, abort, fft_ready,
        output out_valid, out_real, out_imag, out_sop, out_eop,
               sym_idx, frame_done, drop_err
    );

endinterface : ofdm_symbol_sequencer_if
`default_nettype wire

// File: rtl/ofdm_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ofdm_symbol_sequencer
// Brief   : Strips cyclic prefixes and forwards FFT_SIZE payload samples per
//           symbol to the FFT, dropping symbols the FFT cannot accept.
// Revision: 1.0 - initial release
// ============================================================================
module ofdm_symbol_sequencer
    import ofdm_pkg::*;
#(
    parameter int WIDTH    = ofdm_pkg::WIDTH,
    parameter int FFT_SIZE = ofdm_pkg::FFT_SIZE,
    parameter int CP_LEN   = ofdm_pkg::CP_LEN,
    parameter int NUM_SYM  = ofdm_pkg::NUM_SYM
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    ofdm_symbol_sequencer_if.slave  bus
);

    localparam int CNT_W  = clog2_min1(max2(FFT_SIZE, CP_LEN));
    localparam int SIDX_W = clog2_min1(NUM_SYM);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     samp_cnt_q, samp_cnt_d;
    logic [SIDX_W-1:0]    sym_cnt_q, sym_cnt_d;
    logic                 drop_q, drop_d;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_real_q, out_real_d;
    logic [WIDTH-1:0]     out_imag_q, out_imag_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic [SIDX_W-1:0]    sym_idx_q, sym_idx_d;
    logic                 frame_done_q, frame_done_d;
    logic                 drop_err_q, drop_err_d;

    logic                 w_first;
    logic                 w_last_samp;
    logic                 w_cp_end;
    logic                 w_last_sym;
    logic                 w_drop_now;
    logic                 w_step;

    assign w_step      = bus.en && !bus.abort;
    assign w_first     = (samp_cnt_q == '0);
    assign w_last_samp = (samp_cnt_q == CNT_W'(FFT_SIZE - 1));
    assign w_cp_end    = (samp_cnt_q == CNT_W'(CP_LEN - 1));
    assign w_last_sym  = (sym_cnt_q == SIDX_W'(NUM_SYM - 1));
    // fft_ready only matters on the first payload sample; afterwards the latched decision rules.
    assign w_drop_now  = w_first ? !bus.fft_ready : drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            samp_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            drop_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_real_q   <= '0;
            out_imag_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            sym_idx_q    <= '0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            drop_q       <= drop_d;
            out_valid_q  <= out_valid_d;
            out_real_q   <= out_real_d;
            out_imag_q   <= out_imag_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            sym_idx_q    <= sym_idx_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        drop_d     = drop_q;
        if (bus.abort) begin
            state_d    = IDLE;
            samp_cnt_d = '0;
            sym_cnt_d  = '0;
            drop_d     = 1'b0;
        end else if (bus.en) begin
            case (state_q)
                IDLE: begin
                    sym_cnt_d = '0;
                    drop_d    = 1'b0;
                    // The IDLE sample is already CP index 0.
                    if (CP_LEN == 1) begin
                        state_d    = DATA;
                        samp_cnt_d = '0;
                    end else begin
                        state_d    = CP;
                        samp_cnt_d = CNT_W'(1);
                    end
                end
                CP: begin
                    if (w_cp_end) begin
                        state_d    = DATA;
                        samp_cnt_d = '0;
                    end else begin
                        samp_cnt_d = samp_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    drop_d = w_drop_now;
                    if (w_last_samp) begin
                        samp_cnt_d = '0;
                        if (w_last_sym) begin
                            state_d   = IDLE;
                            sym_cnt_d = '0;
                        end else begin
                            state_d   = CP;
                            sym_cnt_d = sym_cnt_q + SIDX_W'(1);
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    samp_cnt_d = '0;
                    sym_cnt_d  = '0;
                    drop_d     = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid_d  = 1'b0;
        out_sop_d    = 1'b0;
        out_eop_d    = 1'b0;
        frame_done_d = 1'b0;
        drop_err_d   = 1'b0;
        out_real_d   = out_real_q;
        out_imag_d   = out_imag_q;
        sym_idx_d    = sym_idx_q;
        if (w_step && (state_q == DATA)) begin
            drop_err_d = w_first && !bus.fft_ready;
            if (!w_drop_now) begin
                out_valid_d = 1'b1;
                out_real_d  = bus.din_real;
                out_imag_d  = bus.din_imag;
                out_sop_d   = w_first;
                out_eop_d   = w_last_samp;
                if (w_first) begin
                    sym_idx_d = sym_cnt_q;
                end
            end
            frame_done_d = w_last_samp && w_last_sym;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_real   = out_real_q;
    assign bus.out_imag   = out_imag_q;
    assign bus.out_sop    = out_sop_q;
    assign bus.out_eop    = out_eop_q;
    assign bus.sym_idx    = sym_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.drop_err   = drop_err_q;

endmodule : ofdm_symbol_sequencer
`default_nettype wire

// File: tb/tb_ofdm_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ofdm_symbol_sequencer
// Brief   : Randomized self-checking bench with a frame-position reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ofdm_symbol_sequencer;
    import ofdm_pkg::*;

    localparam int SYM_LEN = CP_LEN + FFT_SIZE;
    localparam int FRM_LEN = NUM_SYM * SYM_LEN;

    logic clk;
    logic rst_n;

    ofdm_symbol_sequencer_if bus ();

    ofdm_symbol_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: position within the frame in samples.
    int               m_pos;
    bit               m_drop;
    logic [WIDTH-1:0] m_real, m_imag;
    int               m_sidx;
    bit               e_valid, e_sop, e_eop, e_fd, e_derr;

    int n_valid, n_sop, n_eop, n_fd, n_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_drop = 0;
        m_real = '0;
        m_imag = '0;
        m_sidx = 0;
        e_valid = 0; e_sop = 0; e_eop = 0; e_fd = 0; e_derr = 0;
    endtask

    task automatic clr_counts();
        n_valid = 0; n_sop = 0; n_eop = 0; n_fd = 0; n_drop = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid",  32'(bus.out_valid),  32'(e_valid));
        chk("out_sop",    32'(bus.out_sop),    32'(e_sop));
        chk("out_eop",    32'(bus.out_eop),    32'(e_eop));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("drop_err",   32'(bus.drop_err),   32'(e_derr));
        chk("out_real",   32'(bus.out_real),   32'(m_real));
        chk("out_imag",   32'(bus.out_imag),   32'(m_imag));
        chk("sym_idx",    32'(bus.sym_idx),    32'(m_sidx));
        n_valid += int'(bus.out_valid);
        n_sop   += int'(bus.out_sop);
        n_eop   += int'(bus.out_eop);
        n_fd    += int'(bus.frame_done);
        n_drop  += int'(bus.drop_err);
    endtask

    // One clock: drive at negedge, predict, check just after the posedge.
    task automatic cyc(input bit e, input bit a, input bit r);
        logic [WIDTH-1:0] dr, di;
        int off, k, pi;
        dr = WIDTH'($urandom);
        di = WIDTH'($urandom);
        bus.en        = e;
        bus.abort     = a;
        bus.fft_ready = r;
        bus.din_real  = dr;
        bus.din_imag  = di;
        e_valid = 0; e_sop = 0; e_eop = 0; e_fd = 0; e_derr = 0;
        if (a) begin
            m_pos  = 0;
            m_drop = 0;
        end else if (e) begin
            off = m_pos % SYM_LEN;
            k   = m_pos / SYM_LEN;
            if (off >= CP_LEN) begin
                pi = off - CP_LEN;
                if (pi == 0) begin
                    m_drop = !r;
                    e_derr = !r;
                end
                if (!m_drop) begin
                    e_valid = 1;
                    m_real  = dr;
                    m_imag  = di;
                    e_sop   = (pi == 0);
                    e_eop   = (pi == FFT_SIZE - 1);
                    if (pi == 0) m_sidx = k;
                end
                e_fd = (pi == FFT_SIZE - 1) && (k == NUM_SYM - 1);
            end
            m_pos = (m_pos + 1 == FRM_LEN) ? 0 : m_pos + 1;
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.abort     = 1'b0;
        bus.fft_ready = 1'b1;
        bus.din_real  = '0;
        bus.din_imag  = '0;
        model_reset();
        clr_counts();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // en toggling every cycle, fft always ready
        clr_counts();
        for (int i = 0; i < 2 * FRM_LEN; i++) cyc(i % 2 == 0, 0, 1);
        idle_cycles(3);
        chk("toggle_sop_cnt",   32'(n_sop),   32'(NUM_SYM));
        chk("toggle_eop_cnt",   32'(n_eop),   32'(NUM_SYM));
        chk("toggle_valid_cnt", 32'(n_valid), 32'(NUM_SYM * FFT_SIZE));
        chk("toggle_fd_cnt",    32'(n_fd),    32'd1);

        // continuous en
        clr_counts();
        for (int s = 0; s < FRM_LEN; s++) cyc(1, 0, 1);
        idle_cycles(2);
        chk("cont_valid_cnt", 32'(n_valid), 32'(NUM_SYM * FFT_SIZE));
        chk("cont_fd_cnt",    32'(n_fd),    32'd1);

        // FFT busy only at the start of symbol 2
        clr_counts();
        for (int s = 0; s < FRM_LEN; s++) cyc(1, 0, s != 2 * SYM_LEN + CP_LEN);
        idle_cycles(2);
        chk("drop_err_cnt",   32'(n_drop),  32'd1);
        chk("drop_valid_cnt", 32'(n_valid), 32'((NUM_SYM - 1) * FFT_SIZE));
        chk("drop_fd_cnt",    32'(n_fd),    32'd1);

        // abort together with en in the middle of symbol 1
        clr_counts();
        for (int s = 0; s < 30; s++) cyc(1, 0, 1);
        cyc(1, 1, 1);
        for (int s = 0; s < FRM_LEN; s++) cyc(1, 0, 1);
        idle_cycles(2);
        chk("abort_eop_cnt", 32'(n_eop), 32'(NUM_SYM + 1));
        chk("abort_fd_cnt",  32'(n_fd),  32'd1);

        // asynchronous reset between edges at input 50
        for (int s = 0; s < 50; s++) cyc(1, 0, 1);
        bus.en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        clr_counts();
        for (int s = 0; s < FRM_LEN; s++) cyc(1, 0, 1);
        idle_cycles(2);
        chk("rst_valid_cnt", 32'(n_valid), 32'(NUM_SYM * FFT_SIZE));
        chk("rst_fd_cnt",    32'(n_fd),    32'd1);

        // fft_ready toggling after the first payload sample has no effect
        clr_counts();
        for (int s = 0; s < FRM_LEN; s++)
            cyc(1, 0, (s % SYM_LEN == CP_LEN) ? 1'b1 : 1'($urandom));
        idle_cycles(2);
        chk("ready_tog_valid_cnt", 32'(n_valid), 32'(NUM_SYM * FFT_SIZE));
        chk("ready_tog_drop_cnt",  32'(n_drop),  32'd0);

        // fully randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0,
                $urandom_range(3, 0) != 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ofdm_symbol_sequencer
`default_nettype wire
